// File: rtl/bitcoin_pkg.sv
// rtl/bitcoin_pkg.sv - shared types, constants and summary-word layout for the hash result scanner
// Contents: scan FSM state enum, default scan depth, summary-word field positions, summary packer.
package bitcoin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WR_SUM0,
    ST_WR_SUM1
  } scan_state_e;

  localparam int MAX_RESULTS_DEFAULT = 16;

  // Width of counts and indices (num_results, hit_count, best index).
  localparam int CNT_W = 5;

  // Summary word 0 layout: {found, 10'b0, hit_count[4:0], best_idx[15:0]}.
  localparam int SUM_FOUND_BIT = 31;
  localparam int SUM_HITS_LSB  = 16;
  localparam int SUM_IDX_W     = 16;

  localparam logic [31:0] HASH_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] pack_summary(input logic             found,
                                               input logic [CNT_W-1:0] hits,
                                               input logic [CNT_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    w[SUM_FOUND_BIT]           = found;
    w[SUM_HITS_LSB +: CNT_W]   = hits;
    w[0 +: SUM_IDX_W]          = SUM_IDX_W'(idx);
    return w;
  endfunction

endpackage

// File: rtl/hash_min_tracker.sv
// rtl/hash_min_tracker.sv - running minimum and below-target hit counter over captured hash words
// Ports: clk, reset (sync, active-high); clear re-initialises for a new run; valid/index/data
// present one captured word; target is the hit threshold; best_idx/best_hash/hit_count are
// the running results.
module hash_min_tracker
  import bitcoin_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [CNT_W-1:0] index,
  input  logic [31:0]      data,
  input  logic [31:0]      target,
  output logic [CNT_W-1:0] best_idx,
  output logic [31:0]      best_hash,
  output logic [CNT_W-1:0] hit_count
);

  logic [CNT_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      best_hash_q, best_hash_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  always_comb begin
    best_idx_d  = best_idx_q;
    best_hash_d = best_hash_q;
    hit_count_d = hit_count_q;
    if (clear) begin
      best_idx_d  = '0;
      best_hash_d = HASH_INIT;
      hit_count_d = '0;
    end else if (valid) begin
      // Strict compare: an equal later word never displaces the earlier index.
      if (data < best_hash_q) begin
        best_idx_d  = index;
        best_hash_d = data;
      end
      if (data < target) begin
        hit_count_d = hit_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_idx_q  <= '0;
      best_hash_q <= HASH_INIT;
      hit_count_q <= '0;
    end else begin
      best_idx_q  <= best_idx_d;
      best_hash_q <= best_hash_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign best_idx  = best_idx_q;
  assign best_hash = best_hash_q;
  assign hit_count = hit_count_q;

endmodule

// File: rtl/hash_result_scan.sv
// rtl/hash_result_scan.sv - scans hash result words in memory, finds the minimum and counts hits, writes a 2-word summary
// Ports: clk, reset (sync, active-high); start/result_addr/status_addr/num_results/target set up a run;
// done is high in IDLE; mem_* is the shared memory port (1-cycle read latency);
// found/hit_count/best_nonce/best_hash report the last run.
module hash_result_scan
  import bitcoin_pkg::*;
#(
  parameter int          MAX_RESULTS = MAX_RESULTS_DEFAULT,
  parameter logic [31:0] NONCE_BASE  = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       result_addr,
  input  logic [15:0]       status_addr,
  input  logic [CNT_W-1:0]  num_results,
  input  logic [31:0]       target,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              found,
  output logic [CNT_W-1:0]  hit_count,
  output logic [31:0]       best_nonce,
  output logic [31:0]       best_hash
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_RESULTS);

  scan_state_e      state_q, state_d;
  logic [15:0]      res_addr_q, res_addr_d;
  logic [15:0]      stat_addr_q, stat_addr_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  // Read data returns one cycle after its address; these tag the word on mem_read_data.
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;

  logic [CNT_W-1:0] n_clamp;
  logic             trk_clear;
  logic [CNT_W-1:0] best_idx;

  assign n_clamp = (num_results > MAX_N) ? MAX_N : num_results;

  always_comb begin
    state_d        = state_q;
    res_addr_d     = res_addr_q;
    stat_addr_d    = stat_addr_q;
    target_d       = target_q;
    n_d            = n_q;
    idx_d          = idx_q;
    rd_valid_d     = 1'b0;
    rd_idx_d       = idx_q;
    trk_clear      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          res_addr_d  = result_addr;
          stat_addr_d = status_addr;
          target_d    = target;
          n_d         = n_clamp;
          idx_d       = '0;
          trk_clear   = 1'b1;
          state_d     = (n_clamp == '0) ? ST_WR_SUM0 : ST_READ;
        end
      end
      ST_READ: begin
        mem_addr   = res_addr_q + 16'(idx_q);
        rd_valid_d = 1'b1;
        rd_idx_d   = idx_q;
        idx_d      = idx_q + 1'b1;
        if (idx_q == n_q - 1'b1) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WR_SUM0;
      end
      ST_WR_SUM0: begin
        mem_we         = 1'b1;
        mem_addr       = stat_addr_q;
        mem_write_data = pack_summary(found, hit_count, best_idx);
        state_d        = ST_WR_SUM1;
      end
      ST_WR_SUM1: begin
        mem_we         = 1'b1;
        mem_addr       = stat_addr_q + 16'd1;
        mem_write_data = best_hash;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      res_addr_q  <= '0;
      stat_addr_q <= '0;
      target_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      res_addr_q  <= res_addr_d;
      stat_addr_q <= stat_addr_d;
      target_q    <= target_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  hash_min_tracker u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (trk_clear),
    .valid     (rd_valid_q),
    .index     (rd_idx_q),
    .data      (mem_read_data),
    .target    (target_q),
    .best_idx  (best_idx),
    .best_hash (best_hash),
    .hit_count (hit_count)
  );

  assign mem_clk    = clk;
  assign done       = (state_q == ST_IDLE);
  assign found      = (hit_count != '0);
  assign best_nonce = NONCE_BASE + 32'(best_idx);

endmodule

// File: tb/tb_hash_result_scan.sv
// tb/tb_hash_result_scan.sv - directed self-checking bench for hash_result_scan
module tb_hash_result_scan;

  localparam logic [31:0] NB = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] result_addr;
  logic [15:0] status_addr;
  logic [4:0]  num_results;
  logic [31:0] target;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;
  logic        found;
  logic [4:0]  hit_count;
  logic [31:0] best_nonce;
  logic [31:0] best_hash;

  logic [31:0] mem [0:65535];
  logic [15:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hash_result_scan #(.MAX_RESULTS(16), .NONCE_BASE(NB)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .result_addr    (result_addr),
    .status_addr    (status_addr),
    .num_results    (num_results),
    .target         (target),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .found          (found),
    .hit_count      (hit_count),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash)
  );

  // Memory model: reads return one cycle later; writes are logged, not stored.
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we === 1'b1) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_write_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_scan(input string tag, input logic [15:0] ra, input logic [15:0] sa,
                          input logic [4:0] nr, input logic [31:0] tg, input int exp_n,
                          input logic [31:0] exp_w0, input logic [31:0] exp_w1,
                          input logic exp_found, input logic [4:0] exp_hits,
                          input logic [31:0] exp_nonce, input logic [31:0] exp_hash);
    int   wc0;
    int   cyc;
    int   exp_cyc;
    int   k;
    logic addr_ok;
    wc0 = wr_addr_log.size();
    @(negedge clk);
    result_addr = ra; status_addr = sa; num_results = nr; target = tg; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: a running scan must ignore them.
    start = 1'b0; result_addr = 16'hDEAD; status_addr = 16'hBEEF; num_results = 5'd2; target = 32'h0;
    cyc = 1;
    addr_ok = 1'b1;
    for (int j = 0; j < exp_n; j++) begin
      if (mem_addr !== ra + 16'(j) || mem_we !== 1'b0 || done !== 1'b0) addr_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_read_addrs"}, 32'(addr_ok), 32'd1);
    while (done !== 1'b1 && cyc < exp_n + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp_cyc = (exp_n == 0) ? 3 : exp_n + 4;
    check({tag, "_done_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_write_count"}, 32'(wr_addr_log.size() - wc0), 32'd2);
    k = wr_addr_log.size() - 2;
    if (k >= 0) begin
      check({tag, "_w0_addr"}, 32'(wr_addr_log[k]), 32'(sa));
      check({tag, "_w0_data"}, wr_data_log[k], exp_w0);
      check({tag, "_w1_addr"}, 32'(wr_addr_log[k+1]), 32'(sa + 16'd1));
      check({tag, "_w1_data"}, wr_data_log[k+1], exp_w1);
    end
    check({tag, "_found"}, 32'(found), 32'(exp_found));
    check({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({tag, "_best_nonce"}, best_nonce, exp_nonce);
    check({tag, "_best_hash"}, best_hash, exp_hash);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_hash"}, best_hash, exp_hash);
    check({tag, "_hold_hits"}, 32'(hit_count), 32'(exp_hits));
  endtask

  initial begin
    int wc0;
    logic [31:0] v1 [0:15];
    v1 = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h10, 32'h20, 32'h30, 32'h40,
           32'h50, 32'h60, 32'h70, 32'h80, 32'h90, 32'hA0, 32'hB0, 32'hC0};
    for (int j = 0; j < 16; j++) mem[16'h0100 + 16'(j)] = v1[j];
    mem[16'h0300] = 32'h10; mem[16'h0301] = 32'h10; mem[16'h0302] = 32'h20; mem[16'h0303] = 32'h30;
    for (int j = 0; j < 16; j++) mem[16'h0600 + 16'(j)] = 32'h100 + 32'(j);
    for (int j = 16; j < 20; j++) mem[16'h0600 + 16'(j)] = 32'h1;
    mem[16'hFFFE] = 32'hFFFF_FFFF; mem[16'hFFFF] = 32'hFFFF_FFFF;
    mem[16'h0000] = 32'hFFFF_FFFF; mem[16'h0001] = 32'hFFFF_FFFF;

    reset = 1'b1; start = 1'b0; result_addr = '0; status_addr = '0; num_results = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_best_nonce", best_nonce, NB);
    check("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    reset = 1'b0;
    @(posedge clk); #1;

    // Valley with minimum 0x10 at index 4; seven words below 0x45.
    run_scan("valley", 16'h0100, 16'h0200, 5'd16, 32'h45, 16,
             32'h8007_0004, 32'h10, 1'b1, 5'd7, NB + 32'd4, 32'h10);
    // Tie at the minimum keeps index 0.
    run_scan("tie", 16'h0300, 16'h0400, 5'd4, 32'h11, 4,
             32'h8002_0000, 32'h10, 1'b1, 5'd2, NB, 32'h10);
    // Empty run.
    run_scan("empty", 16'h0300, 16'h0500, 5'd0, 32'h45, 0,
             32'h0, 32'hFFFF_FFFF, 1'b0, 5'd0, NB, 32'hFFFF_FFFF);
    // num_results 20 clamps to 16; indices 16..19 hold 0x1 and must not be read.
    run_scan("clamp", 16'h0600, 16'h0650, 5'd20, 32'h105, 16,
             32'h8005_0000, 32'h100, 1'b1, 5'd5, NB, 32'h100);
    // Zero target, all-ones data, address wrap.
    run_scan("wrap", 16'hFFFE, 16'h0800, 5'd4, 32'h0, 4,
             32'h0, 32'hFFFF_FFFF, 1'b0, 5'd0, NB, 32'hFFFF_FFFF);

    // Reset in READ cycle 5 of a 16-word run.
    wc0 = wr_addr_log.size();
    @(negedge clk);
    result_addr = 16'h0100; status_addr = 16'h0700; num_results = 5'd16; target = 32'h45; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy", 32'(done), 32'd0);
    check("abort_addr_j5", 32'(mem_addr), 32'h0105);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_done", 32'(done), 32'd1);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_found", 32'(found), 32'd0);
    check("abort_best_nonce", best_nonce, NB);
    check("abort_best_hash", best_hash, 32'hFFFF_FFFF);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_writes", 32'(wr_addr_log.size() - wc0), 32'd0);
    check("abort_idle", 32'(done), 32'd1);

    // Reset takes priority over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; num_results = 5'd4; result_addr = 16'h0300;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("rst_prio_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("rst_prio_still_idle", 32'(done), 32'd1);
    check("rst_prio_mem_addr", 32'(mem_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hash_result_scan.md
HASH_RESULT_SCAN -- requirements
Module: hash_result_scan

Interface
REQ-001 SHALL have parameter MAX_RESULTS, default 16, meaning the maximum number of hash result words scanned per run.
REQ-002 SHALL have parameter NONCE_BASE, default 0, meaning the nonce value that result index 0 maps to.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begin scan; sampled only in IDLE.
REQ-007 SHALL have port result_addr, input, 16, base address of the H0 result words written by the hashing stage.
REQ-008 SHALL have port status_addr, input, 16, base address of the 2-word summary record.
REQ-009 SHALL have port num_results, input, 5, count of words to scan; values above MAX_RESULTS clamp to MAX_RESULTS.
REQ-010 SHALL have port target, input, 32, difficulty threshold; a word is a hit when hash < target (unsigned).
REQ-011 SHALL have port done, output, 1, high while in IDLE.
REQ-012 SHALL have ports mem_clk, mem_we, mem_addr, mem_write_data and mem_read_data with widths 1, 1, 16, 32 and 32, forming the shared memory port; mem_clk = clk.
REQ-013 SHALL have port found, output, 1, at least one hit in the last run.
REQ-014 SHALL have port hit_count, output, 5, number of hits in the last run.
REQ-015 SHALL have port best_nonce, output, 32, NONCE_BASE + index of the minimum hash.
REQ-016 SHALL have port best_hash, output, 32, minimum hash value seen.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, WR_SUM0, WR_SUM1.
REQ-018 SHALL transition IDLE->READ on start (N = clamped num_results ≥ 1), READ->DRAIN after N address cycles, DRAIN->WR_SUM0, WR_SUM0->WR_SUM1, WR_SUM1->IDLE.
REQ-019 SHALL, when N = 0, go IDLE->WR_SUM0 directly with found=0, hit_count=0, best_hash=32'hFFFFFFFF and best_nonce=NONCE_BASE.
REQ-020 SHALL latch result_addr, status_addr, target and N on the start cycle; input changes during a run are ignored.
REQ-021 SHALL present mem_addr = result_addr + j with mem_we=0 in READ cycle j (j = 0..N-1).
REQ-022 SHALL treat memory read latency as 1 cycle: data for index j is valid in the cycle after its address and is captured at the end of that cycle; DRAIN captures index N-1.
REQ-023 SHALL initialise best_hash=32'hFFFFFFFF, best_idx=0 and hit_count=0 on start.
REQ-024 SHALL replace the best candidate only when the captured word < best_hash (strict); ties keep the lowest index.
REQ-025 SHALL increment hit_count by one per captured word < target; target=0 yields no hits.
REQ-026 SHALL, in WR_SUM0, write {found, 10'b0, hit_count, 16'(best_idx)} to status_addr with mem_we=1.
REQ-027 SHALL, in WR_SUM1, write best_hash to status_addr+1 with mem_we=1; mem_we=0 in all other states.
REQ-028 SHALL assert done exactly N+4 cycles after the start-sampling edge (3 cycles when N=0).
REQ-029 SHALL hold found, hit_count, best_nonce and best_hash stable from WR_SUM0 until the next accepted start.
REQ-030 SHALL ignore start outside IDLE.
REQ-031 SHALL wrap address arithmetic modulo 2^16.

Reset
REQ-032 SHALL, on reset, enter IDLE with done=1, mem_we=0, mem_addr=0, mem_write_data=0, found=0, hit_count=0, best_nonce=NONCE_BASE and best_hash=32'hFFFFFFFF.
REQ-033 SHALL let reset asserted mid-run abort the run immediately with no further memory writes, and take priority over start.

Structure
REQ-034 SHALL take the state enum, the MAX_RESULTS default and the summary-word field layout from shared package bitcoin_pkg.
REQ-035 SHALL place the running-minimum/hit-count datapath in one sub-module, hash_min_tracker (clear, valid, index, data in; best_idx, best_hash, hit_count out).

Verification
REQ-036 SHALL cover: N=16 with words 0x50,0x40,…(decreasing by 0x10 then increasing) and target=0x45 -> best_nonce=index of 0x40 region minimum, hit_count = number of words < 0x45, summary at status_addr/+1.
REQ-037 SHALL cover: N=4, words {0x10,0x10,0x20,0x30}, target=0x11 -> best_nonce=NONCE_BASE+0, hit_count=2, found=1.
REQ-038 SHALL cover: N=0 -> summary word0=0, word1=0xFFFFFFFF, done 3 cycles after start.
REQ-039 SHALL cover: num_results=20 -> exactly 16 reads, done 20 cycles after start.
REQ-040 SHALL cover: reset asserted in READ cycle 5 of N=16 -> IDLE next cycle, no write to status_addr, outputs at reset values.
REQ-041 SHALL cover: target=0, all words 0xFFFFFFFF, result_addr=0xFFFE -> found=0, best_hash=0xFFFFFFFF, best_nonce=NONCE_BASE+0, read addresses wrap 0xFFFE,0xFFFF,0x0000…
